// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and PC field helpers for the N-way instruction cache
package icache_pkg;

  typedef enum logic [1:0] {IDLE, TAG, MISS, RESP} state_e;

  function automatic int log2c(input int v);
    return (v <= 1) ? 0 : $clog2(v);
  endfunction

  function automatic logic [63:0] pc_off(input logic [63:0] pc, input int off_w);
    return pc & ((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int off_w, input int idx_w);
    return (pc >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int off_w, input int idx_w);
    return pc >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// rtl/icache_victim_sel.sv - victim way: lowest invalid way, else the round-robin pointer
module icache_victim_sel #(
  parameter int WAY_NUM = 4,
  parameter int WAY_W   = 2
) (
  input  logic [WAY_NUM-1:0] valid,
  input  logic [WAY_W-1:0]   rr_ptr,
  output logic [WAY_W-1:0]   victim,
  output logic               advance
);

  always_comb begin
    victim  = rr_ptr;
    advance = 1'b1;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim  = WAY_W'(w);
        advance = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_model.sv
// rtl/sram_model.sv - single-port synchronous RAM, registered read data
module sram_model #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data only moves on a read, so it holds while the cache stalls.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative instruction cache with refill, squash and flush
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAY_NUM     = 4,
  parameter int SET_NUM     = 64,
  parameter int LINE_BYTES  = 64,
  parameter int FETCH_BYTES = 16,
  parameter int PC_WIDTH    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f0_valid_i,
  input  logic [PC_WIDTH-1:0]      f0_pc_i,
  output logic                     icache_valid_o,
  output logic [PC_WIDTH-1:0]      icache_pc_o,
  output logic [8*FETCH_BYTES-1:0] icache_data_o,
  input  logic                     stall_icache_i,
  input  logic                     squash_pipe_i,
  output logic                     icache_miss_valid_o,
  input  logic                     icache_miss_ready_i,
  output logic [PC_WIDTH-1:0]      icache_miss_addr_o,
  input  logic                     refill_icache_valid_i,
  output logic                     refill_icache_ready_o,
  input  logic [8*LINE_BYTES-1:0]  refill_icache_data_i,
  input  logic                     flush_i,
  output logic                     flush_done_o
);

  localparam int OFF_W   = log2c(LINE_BYTES);
  localparam int IDX_W   = log2c(SET_NUM);
  localparam int TAG_W   = PC_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W   = log2c(WAY_NUM);
  localparam int LINE_W  = 8 * LINE_BYTES;
  localparam int FETCH_W = 8 * FETCH_BYTES;
  localparam int FB_W    = log2c(FETCH_BYTES);

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                squashed_q;
  logic                flush_pending_q;
  logic                flush_done_q;
  logic [LINE_W-1:0]   line_q;
  logic [WAY_NUM-1:0]  valid_q [SET_NUM];
  logic [WAY_W-1:0]    rr_q    [SET_NUM];

  logic [IDX_W-1:0]    req_idx, cur_idx, ram_addr;
  logic [TAG_W-1:0]    cur_tag;
  logic [OFF_W-1:0]    cur_off;
  logic [TAG_W-1:0]    tag_rd  [WAY_NUM];
  logic [LINE_W-1:0]   data_rd [WAY_NUM];
  logic [WAY_NUM-1:0]  way_match, way_we;
  logic [WAY_W-1:0]    victim;
  logic                advance, hit, accept, miss_fire, refill_fire, flush_take, ram_en;
  logic [LINE_W-1:0]   hit_line, out_line;

  assign req_idx = IDX_W'(pc_idx(64'(f0_pc_i), OFF_W, IDX_W));
  assign cur_idx = IDX_W'(pc_idx(64'(pc_q), OFF_W, IDX_W));
  assign cur_tag = TAG_W'(pc_tag(64'(pc_q), OFF_W, IDX_W));
  assign cur_off = OFF_W'(pc_off(64'(pc_q), OFF_W));

  always_comb begin
    way_match = '0;
    hit_line  = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      way_match[w] = valid_q[cur_idx][w] && (tag_rd[w] == cur_tag);
      if (way_match[w]) hit_line = hit_line | data_rd[w];
    end
  end

  // A multi-way match is treated as a miss rather than merging lines.
  assign hit         = (state_q == TAG) && $onehot(way_match);
  assign accept      = f0_valid_i && !stall_icache_i && !squash_pipe_i && !flush_pending_q &&
                       ((state_q == IDLE) || hit || (state_q == RESP));
  assign miss_fire   = (state_q == TAG) && !hit && icache_miss_ready_i;
  assign refill_fire = (state_q == MISS) && refill_icache_valid_i;
  assign flush_take  = flush_pending_q && ((state_q == IDLE) || (hit && !stall_icache_i));
  assign ram_en      = accept || refill_fire;
  assign ram_addr    = refill_fire ? cur_idx : req_idx;
  assign way_we      = WAY_NUM'(refill_fire) << victim;

  icache_victim_sel #(.WAY_NUM(WAY_NUM), .WAY_W(WAY_W)) u_victim (
    .valid   (valid_q[cur_idx]),
    .rr_ptr  (rr_q[cur_idx]),
    .victim  (victim),
    .advance (advance)
  );

  for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
    sram_model #(.DEPTH(SET_NUM), .WIDTH(TAG_W), .AW(IDX_W)) u_tag (
      .clk (clk), .en (ram_en), .we (way_we[w]), .addr (ram_addr),
      .wdata (cur_tag), .rdata (tag_rd[w])
    );
    sram_model #(.DEPTH(SET_NUM), .WIDTH(LINE_W), .AW(IDX_W)) u_data (
      .clk (clk), .en (ram_en), .we (way_we[w]), .addr (ram_addr),
      .wdata (refill_icache_data_i), .rdata (data_rd[w])
    );
  end

  assign out_line              = (state_q == RESP) ? line_q : hit_line;
  assign icache_valid_o        = hit || (state_q == RESP);
  assign icache_pc_o           = pc_q;
  assign icache_data_o         = icache_valid_o ?
                                 FETCH_W'(out_line >> (int'(cur_off >> FB_W) * FETCH_W)) : '0;
  assign icache_miss_valid_o   = (state_q == TAG) && !hit;
  assign icache_miss_addr_o    = {cur_tag, cur_idx, OFF_W'(0)};
  assign refill_icache_ready_o = (state_q == MISS);
  assign flush_done_o          = flush_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      pc_q            <= '0;
      squashed_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
      line_q          <= '0;
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      flush_done_q    <= flush_take;
      flush_pending_q <= flush_i || (flush_pending_q && !flush_take);
      if (accept) pc_q <= f0_pc_i;

      case (state_q)
        IDLE: if (accept) state_q <= TAG;
        TAG: begin
          // An accepted miss handshake must complete even if squashed alongside it.
          if (miss_fire) begin
            state_q    <= MISS;
            squashed_q <= squash_pipe_i;
          end else if (squash_pipe_i) begin
            state_q <= IDLE;
          end else if (hit && !stall_icache_i) begin
            state_q <= accept ? TAG : IDLE;
          end
        end
        MISS: begin
          if (squash_pipe_i) squashed_q <= 1'b1;
          if (refill_fire) begin
            line_q  <= refill_icache_data_i;
            state_q <= (squashed_q || squash_pipe_i) ? IDLE : RESP;
          end
        end
        RESP: begin
          if (squash_pipe_i)        state_q <= IDLE;
          else if (!stall_icache_i) state_q <= accept ? TAG : IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (refill_fire) begin
        valid_q[cur_idx][victim] <= 1'b1;
        if (advance) rr_q[cur_idx] <= rr_q[cur_idx] + 1'b1;
      end
      // Placed after the refill write so a coincident flush wins.
      if (flush_take) begin
        for (int s = 0; s < SET_NUM; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// tb/tb_icache_nway.sv - scoreboard bench for icache_nway
module tb_icache_nway;
  import icache_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         f0_valid_i;
  logic [63:0]  f0_pc_i;
  logic         icache_valid_o;
  logic [63:0]  icache_pc_o;
  logic [127:0] icache_data_o;
  logic         stall_icache_i;
  logic         squash_pipe_i;
  logic         icache_miss_valid_o;
  logic         icache_miss_ready_i;
  logic [63:0]  icache_miss_addr_o;
  logic         refill_icache_valid_i;
  logic         refill_icache_ready_o;
  logic [511:0] refill_icache_data_i;
  logic         flush_i;
  logic         flush_done_o;

  icache_nway dut (
    .clk (clk), .rst_n (rst_n),
    .f0_valid_i (f0_valid_i), .f0_pc_i (f0_pc_i),
    .icache_valid_o (icache_valid_o), .icache_pc_o (icache_pc_o), .icache_data_o (icache_data_o),
    .stall_icache_i (stall_icache_i), .squash_pipe_i (squash_pipe_i),
    .icache_miss_valid_o (icache_miss_valid_o), .icache_miss_ready_i (icache_miss_ready_i),
    .icache_miss_addr_o (icache_miss_addr_o),
    .refill_icache_valid_i (refill_icache_valid_i), .refill_icache_ready_o (refill_icache_ready_o),
    .refill_icache_data_i (refill_icache_data_i),
    .flush_i (flush_i), .flush_done_o (flush_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]  pc;
    logic [127:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          deliv_cnt = 0;
  int          deliv_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          miss_seen = 0;
  int          multihit = 0;
  int          refill_cnt = 0;
  logic [63:0] miss_addr_q = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [63:0] addr);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[i*8 +: 8] = 8'(i + int'(addr[15:8]));
    return l;
  endfunction

  function automatic logic [127:0] slice_of(input logic [63:0] pc);
    logic [511:0] l;
    l = line_of(pc & ~64'h3f);
    return l[pc[5:4]*128 +: 128];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: one delivery per cycle with valid high and no stall.
  always @(negedge clk) begin
    if (rst_n && icache_valid_o && !stall_icache_i) begin
      exp_t e;
      deliv_cnt++;
      deliv_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_delivery", icache_pc_o, 0);
      end else begin
        e = sb.pop_front();
        check("deliv_pc", icache_pc_o, e.pc);
        check("deliv_data", icache_data_o, e.data);
      end
    end
    if (flush_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dut.state_q == TAG && !$onehot0(dut.way_match)) multihit++;
  end

  // Memory side: accept each miss, refill three cycles later.
  initial begin
    icache_miss_ready_i   = 1'b0;
    refill_icache_valid_i = 1'b0;
    refill_icache_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      icache_miss_ready_i   = 1'b0;
      refill_icache_valid_i = 1'b0;
      if (refill_cnt > 0) begin
        refill_cnt--;
        if (refill_cnt == 0) begin
          refill_icache_valid_i = 1'b1;
          refill_icache_data_i  = line_of(miss_addr_q);
        end
      end else if (rst_n && icache_miss_valid_o) begin
        icache_miss_ready_i = 1'b1;
        miss_addr_q         = icache_miss_addr_o;
        miss_seen++;
        refill_cnt          = 3;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic wait_deliv(input int target);
    int t;
    t = 0;
    while (deliv_cnt < target && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("deliv_count", deliv_cnt, target);
  endtask

  task automatic wait_miss_state();
    int t;
    t = 0;
    while (!refill_icache_ready_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("reach_miss", refill_icache_ready_o, 1);
  endtask

  task automatic fetch(input logic [63:0] pc, input bit exp_hit, input string tag);
    int m0, d0;
    m0 = miss_seen;
    d0 = deliv_cnt;
    @(posedge clk); #1;
    f0_valid_i = 1'b1;
    f0_pc_i    = pc;
    sb.push_back('{pc: pc, data: slice_of(pc)});
    @(posedge clk); #1;
    f0_valid_i = 1'b0;
    @(negedge clk);
    check({tag, "_hit_latency"}, icache_valid_o, exp_hit);
    wait_deliv(d0 + 1);
    check({tag, "_miss_count"}, miss_seen - m0, exp_hit ? 0 : 1);
    if (!exp_hit) check({tag, "_miss_addr"}, miss_addr_q, pc & ~64'h3f);
  endtask

  localparam logic [63:0] PC_A    = 64'h2000_0040;
  localparam logic [63:0] PC_COLD = 64'h1000_0048;
  localparam logic [63:0] PC_RE   = 64'h1000_0058;
  localparam logic [63:0] PC_SQ   = 64'h3000_0100;
  localparam logic [63:0] PC_FL   = 64'h4000_0200;

  initial begin
    int d0, m0, fd0;
    rst_n          = 1'b0;
    f0_valid_i     = 1'b0;
    f0_pc_i        = '0;
    stall_icache_i = 1'b0;
    squash_pipe_i  = 1'b0;
    flush_i        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", icache_valid_o, 0);
    check("rst_miss_valid", icache_miss_valid_o, 0);
    check("rst_refill_ready", refill_icache_ready_o, 0);
    check("rst_flush_done", flush_done_o, 0);
    check("rst_pc", icache_pc_o, 0);
    check("rst_data", icache_data_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Five tags into set 1: ways fill, the fifth evicts way 0.
    for (int k = 0; k < 5; k++) fetch(PC_A + 64'(k) * 64'h2000, 1'b0, "fill");
    check("rr_after_five", dut.rr_q[1], 1);
    fetch(PC_A, 1'b0, "evicted_refetch");
    check("rr_after_six", dut.rr_q[1], 2);

    fetch(PC_COLD, 1'b0, "cold");
    fetch(PC_RE, 1'b1, "rehit");
    fetch(PC_A + 64'h6000, 1'b1, "a3_hit");
    fetch(PC_A + 64'h8000, 1'b1, "a4_hit");

    // Squash the cycle after the miss handshake: refill lands, nothing delivered.
    d0 = deliv_cnt;
    m0 = miss_seen;
    @(posedge clk); #1;
    f0_valid_i = 1'b1;
    f0_pc_i    = PC_SQ;
    @(posedge clk); #1;
    f0_valid_i = 1'b0;
    wait_miss_state();
    squash_pipe_i = 1'b1;
    @(posedge clk); #1;
    squash_pipe_i = 1'b0;
    repeat (10) @(posedge clk);
    check("squash_miss_count", miss_seen - m0, 1);
    check("squash_no_delivery", deliv_cnt, d0);
    check("squash_idle_ready", refill_icache_ready_o, 0);
    fetch(PC_SQ, 1'b1, "post_squash");

    // Flush raised during a miss: response first, then flush_done.
    d0  = deliv_cnt;
    fd0 = done_cnt;
    @(posedge clk); #1;
    f0_valid_i = 1'b1;
    f0_pc_i    = PC_FL;
    sb.push_back('{pc: PC_FL, data: slice_of(PC_FL)});
    @(posedge clk); #1;
    f0_valid_i = 1'b0;
    wait_miss_state();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    wait_deliv(d0 + 1);
    repeat (6) @(posedge clk);
    check("flush_done_count", done_cnt - fd0, 1);
    check("flush_done_latency", done_cyc - deliv_cyc, 2);
    fetch(PC_RE, 1'b0, "flushed_re");
    fetch(PC_A + 64'h6000, 1'b0, "flushed_a3");

    // Stall a hit for three cycles with the next request waiting behind it.
    d0 = deliv_cnt;
    @(posedge clk); #1;
    f0_valid_i = 1'b1;
    f0_pc_i    = PC_RE;
    sb.push_back('{pc: PC_RE, data: slice_of(PC_RE)});
    @(posedge clk); #1;
    stall_icache_i = 1'b1;
    f0_pc_i        = PC_COLD;
    sb.push_back('{pc: PC_COLD, data: slice_of(PC_COLD)});
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", icache_valid_o, 1);
      check("stall_pc", icache_pc_o, PC_RE);
      check("stall_data", icache_data_o, slice_of(PC_RE));
      @(posedge clk); #1;
    end
    stall_icache_i = 1'b0;
    @(posedge clk); #1;
    f0_valid_i = 1'b0;
    wait_deliv(d0 + 2);

    repeat (4) @(posedge clk);
    check("multi_hit_events", multihit, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
